// File: rtl/shift_pipe_unit.sv
// Pipelined barrel shifter (SRL/SRA/SLL/ROR), latency STAGES enabled cycles, one word per enabled cycle.
// No backpressure: EN=0 freezes every stage; the consumer must take the word whenever R_OUT=1.
module shift_pipe_unit #(
  parameter int N      = 16,
  parameter int STAGES = 2,
  localparam int SW    = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          R_IN,
  input  logic [N-1:0]  D_IN,
  input  logic [SW-1:0] SH_AMT,
  input  logic [1:0]    MODE,
  output logic          R_OUT,
  output logic [N-1:0]  D_OUT,
  output logic          LOST
);

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_SLL = 2'b10;

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("shift_pipe_unit: N must be a power of two >= 2");
  end
  if (STAGES < 1 || STAGES > SW) begin : g_bad_stages
    $error("shift_pipe_unit: STAGES must be in 1..$clog2(N)");
  end

  // One binary level: shift by sh (a power of two), returning {bits_lost, result}.
  function automatic logic [N:0] shift_level(input logic [N-1:0] d,
                                             input logic [1:0]   m,
                                             input int           sh);
    logic [N-1:0] ones, lo_mask, hi_mask, r;
    logic         lost;
    ones    = '1;
    lo_mask = ones >> (N - sh);
    hi_mask = ~(ones >> sh);
    r       = '0;
    lost    = 1'b0;
    case (m)
      MODE_SRL: begin
        r    = d >> sh;
        lost = |(d & lo_mask);
      end
      MODE_SRA: begin
        r    = (d >> sh) | (d[N-1] ? hi_mask : '0);
        lost = |(d & lo_mask);
      end
      MODE_SLL: begin
        r    = d << sh;
        lost = |(d & hi_mask);
      end
      default: begin
        r    = (d >> sh) | (d << (N - sh));
        lost = 1'b0;
      end
    endcase
    return {lost, r};
  endfunction

  // Index 0 is the input port side; index s+1 is the register output of stage s.
  logic          pipe_vld  [STAGES+1];
  logic [N-1:0]  pipe_dat  [STAGES+1];
  logic          pipe_lost [STAGES+1];
  logic [SW-1:0] pipe_amt  [STAGES];
  logic [1:0]    pipe_mode [STAGES];

  assign pipe_vld[0]  = R_IN;
  assign pipe_dat[0]  = D_IN;
  assign pipe_lost[0] = 1'b0;
  assign pipe_amt[0]  = SH_AMT;
  assign pipe_mode[0] = MODE;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic          vld_q, vld_d;
    logic          lost_q, lost_d;
    logic [N-1:0]  dat_q, dat_d;
    logic [N-1:0]  sh_dat;
    logic [SW-1:0] sh_amt;
    logic [SW-1:0] bit_k;
    logic [N:0]    lvl;
    logic          sh_lost;
    logic          load;

    // Levels k with floor(k*STAGES/SW) == s sit in front of this register; used amount bits are cleared.
    always_comb begin
      sh_dat  = pipe_dat[s];
      sh_amt  = pipe_amt[s];
      sh_lost = pipe_lost[s];
      lvl     = '0;
      bit_k   = '0;
      for (int k = 0; k < SW; k++) begin
        bit_k = SW'(1) << k;
        if (((k * STAGES) / SW) == s && (sh_amt & bit_k) != '0) begin
          lvl     = shift_level(sh_dat, pipe_mode[s], 1 << k);
          sh_dat  = lvl[N-1:0];
          sh_lost = sh_lost | lvl[N];
          sh_amt  = sh_amt & ~bit_k;
        end
      end
      load   = EN && pipe_vld[s];
      vld_d  = EN ? pipe_vld[s] : vld_q;
      dat_d  = load ? sh_dat : dat_q;
      lost_d = load ? sh_lost : lost_q;
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        vld_q  <= 1'b0;
        dat_q  <= '0;
        lost_q <= 1'b0;
      end else begin
        vld_q  <= vld_d;
        dat_q  <= dat_d;
        lost_q <= lost_d;
      end
    end

    assign pipe_vld[s+1]  = vld_q;
    assign pipe_dat[s+1]  = dat_q;
    assign pipe_lost[s+1] = lost_q;

    // The residual amount and mode are only needed by later stages.
    if (s < STAGES - 1) begin : g_side
      logic [SW-1:0] amt_q, amt_d;
      logic [1:0]    mode_q, mode_d;

      always_comb begin
        amt_d  = load ? sh_amt : amt_q;
        mode_d = load ? pipe_mode[s] : mode_q;
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          amt_q  <= '0;
          mode_q <= '0;
        end else begin
          amt_q  <= amt_d;
          mode_q <= mode_d;
        end
      end

      assign pipe_amt[s+1]  = amt_q;
      assign pipe_mode[s+1] = mode_q;
    end
  end

  assign R_OUT = pipe_vld[STAGES];
  assign D_OUT = pipe_dat[STAGES];
  assign LOST  = pipe_lost[STAGES];

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Bench for shift_pipe_unit: N=16/STAGES=2, N=16/STAGES=1 and N=32/STAGES=5 instances in lockstep.
// A scoreboard per instance holds expected words with the enabled-edge count at which each must emerge.
module tb_shift_pipe_unit;

  logic        CLK = 1'b0;
  logic        RST, EN, R_IN;
  logic [1:0]  MODE;
  logic [15:0] D_IN;
  logic [3:0]  SH_AMT;
  logic [31:0] D32;
  logic [4:0]  SH32;

  logic        r_out_a, lost_a, r_out_b, lost_b, r_out_c, lost_c;
  logic [15:0] d_out_a, d_out_b;
  logic [31:0] d_out_c;

  always #5 CLK = ~CLK;

  shift_pipe_unit #(.N(16), .STAGES(2)) u_dut (
    .CLK(CLK), .RST(RST), .EN(EN), .R_IN(R_IN), .D_IN(D_IN), .SH_AMT(SH_AMT), .MODE(MODE),
    .R_OUT(r_out_a), .D_OUT(d_out_a), .LOST(lost_a));

  shift_pipe_unit #(.N(16), .STAGES(1)) u_s1 (
    .CLK(CLK), .RST(RST), .EN(EN), .R_IN(R_IN), .D_IN(D_IN), .SH_AMT(SH_AMT), .MODE(MODE),
    .R_OUT(r_out_b), .D_OUT(d_out_b), .LOST(lost_b));

  shift_pipe_unit #(.N(32), .STAGES(5)) u_w32 (
    .CLK(CLK), .RST(RST), .EN(EN), .R_IN(R_IN), .D_IN(D32), .SH_AMT(SH32), .MODE(MODE),
    .R_OUT(r_out_c), .D_OUT(d_out_c), .LOST(lost_c));

  typedef struct {
    logic [31:0] dat;
    logic        lost;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] d;
    logic [3:0]  amt;
    logic [15:0] exp_d;
    logic        exp_lost;
  } vec_t;

  exp_t        sbq [3][$];
  vec_t        tbl [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          en_count = 0;
  bit          en_edge = 1'b0;
  logic [31:0] last_a_dat = '0;
  logic        last_a_lost = 1'b0;

  function automatic logic [32:0] model(input logic [31:0] d, input int amt,
                                        input logic [1:0] m, input int w);
    logic [31:0] mask, low, r;
    logic [63:0] x;
    logic        lost;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    low  = (32'd1 << amt) - 32'd1;
    r    = '0;
    lost = 1'b0;
    x    = '0;
    case (m)
      2'b00: begin r = d >> amt; lost = |(d & low); end
      2'b01: begin
        r = d >> amt;
        if (d[w-1]) r = r | (mask & ~(mask >> amt));
        lost = |(d & low);
      end
      2'b10: begin x = {32'h0, d} << amt; r = x[31:0] & mask; lost = |(x >> w); end
      default: r = ((d >> amt) | (d << (w - amt))) & mask;
    endcase
    return {lost, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] m, input logic [15:0] d,
                       input logic [3:0] a, input logic [31:0] d32, input logic [4:0] a32);
    R_IN = r; MODE = m; D_IN = d; SH_AMT = a; D32 = d32; SH32 = a32;
  endtask

  // One clock: record pushes at the rising edge, check every instance at the falling edge.
  task automatic tick();
    exp_t        e;
    logic        ro, lo;
    logic [31:0] dout;
    @(posedge CLK);
    en_edge = EN && !RST;
    if (RST) for (int i = 0; i < 3; i++) sbq[i].delete();
    if (en_edge) begin
      en_count++;
      if (R_IN) begin
        {e.lost, e.dat} = model({16'h0, D_IN}, int'(SH_AMT), MODE, 16);
        e.due = en_count + 1; sbq[0].push_back(e);
        e.due = en_count;     sbq[1].push_back(e);
        {e.lost, e.dat} = model(D32, int'(SH32), MODE, 32);
        e.due = en_count + 4; sbq[2].push_back(e);
      end
    end
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin ro = r_out_a; dout = {16'h0, d_out_a}; lo = lost_a; end
        1:       begin ro = r_out_b; dout = {16'h0, d_out_b}; lo = lost_b; end
        default: begin ro = r_out_c; dout = d_out_c;          lo = lost_c; end
      endcase
      if (en_edge && ro) begin
        if (sbq[i].size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb%0d_unexpected: got R_OUT=1 D_OUT=%h, want no output", i, dout);
        end else begin
          e = sbq[i].pop_front();
          chk($sformatf("sb%0d_dat", i), dout, e.dat);
          chk($sformatf("sb%0d_lost", i), 32'(lo), 32'(e.lost));
          chk($sformatf("sb%0d_latency_edge", i), 32'(en_count), 32'(e.due));
          if (i == 0) begin last_a_dat = e.dat; last_a_lost = e.lost; end
        end
      end else if (en_edge && sbq[i].size() != 0 && sbq[i][0].due <= en_count) begin
        n_cmp++; n_bad++;
        $display("FAIL sb%0d_missing: got R_OUT=0, want word %h", i, sbq[i][0].dat);
        void'(sbq[i].pop_front());
      end
    end
  endtask

  initial begin
    logic [15:0] d, d0;

    tbl[0] = '{2'b00, 16'h8001, 4'd1,  16'h4000, 1'b1};
    tbl[1] = '{2'b01, 16'h8000, 4'd4,  16'hF800, 1'b0};
    tbl[2] = '{2'b10, 16'h8001, 4'd1,  16'h0002, 1'b1};
    tbl[3] = '{2'b11, 16'h0001, 4'd1,  16'h8000, 1'b0};
    tbl[4] = '{2'b01, 16'h8001, 4'd0,  16'h8001, 1'b0};
    tbl[5] = '{2'b10, 16'h00FF, 4'd8,  16'hFF00, 1'b0};
    tbl[6] = '{2'b11, 16'h1234, 4'd4,  16'h4123, 1'b0};
    tbl[7] = '{2'b01, 16'h7FF0, 4'd15, 16'h0000, 1'b1};

    RST = 1'b1; EN = 1'b0;
    drive(1'b1, 2'b10, 16'hFFFF, 4'd3, 32'hFFFF_FFFF, 5'd3);
    tick(); tick();
    chk("reset_r_out", 32'(r_out_a), 0);
    chk("reset_d_out", 32'(d_out_a), 0);
    chk("reset_lost", 32'(lost_a), 0);
    chk("reset_w32_d_out", d_out_c, 0);
    chk("reset_w32_r_out", 32'(r_out_c), 0);

    RST = 1'b0; EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].mode, tbl[i].d, tbl[i].amt, $urandom, 5'($urandom_range(0, 31)));
      tick();
      chk($sformatf("tbl%0d_not_early", i), 32'(r_out_a), 0);
      R_IN = 1'b0;
      tick();
      chk($sformatf("tbl%0d_r_out", i), 32'(r_out_a), 1);
      chk($sformatf("tbl%0d_d_out", i), 32'(d_out_a), 32'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_lost", i), 32'(lost_a), 32'(tbl[i].exp_lost));
    end

    d0 = '0;
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      if (i == 0) d0 = d;
      drive(1'b1, 2'(i % 4), d, 4'(i), $urandom, 5'(2 * i));
      tick();
      if (i > 0) chk($sformatf("stream_r_out%0d", i), 32'(r_out_a), 1);
      if (i == 1) chk("stream_amt0_passthru", 32'(d_out_a), 32'(d0));
    end
    R_IN = 1'b0;
    tick();
    chk("stream_r_out_last", 32'(r_out_a), 1);

    drive(1'b1, 2'b10, 16'h00F0, 4'd4, 32'h0000_F0F0, 5'd4);
    tick();
    chk("stall_pre_r_out", 32'(r_out_a), 0);
    EN = 1'b0;
    drive(1'b1, 2'b00, 16'hDEAD, 4'd7, 32'hDEAD_BEEF, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_r_out", i), 32'(r_out_a), 0);
      chk($sformatf("stall%0d_d_out", i), 32'(d_out_a), last_a_dat);
      chk($sformatf("stall%0d_lost", i), 32'(lost_a), 32'(last_a_lost));
    end
    EN = 1'b1; R_IN = 1'b0;
    tick();
    chk("stall_post_r_out", 32'(r_out_a), 1);
    chk("stall_post_d_out", 32'(d_out_a), 32'h0F00);

    drive(1'b1, 2'b01, 16'h8001, 4'd1, $urandom, 5'd1);
    tick();
    chk("bubble_r_out0", 32'(r_out_a), 0);
    R_IN = 1'b0;
    tick();
    chk("bubble_r_out1", 32'(r_out_a), 1);
    chk("bubble_d_out_a", 32'(d_out_a), 32'hC000);
    drive(1'b1, 2'b00, 16'h000F, 4'd2, $urandom, 5'd2);
    tick();
    chk("bubble_r_out2", 32'(r_out_a), 0);
    chk("bubble_hold_d_out", 32'(d_out_a), 32'hC000);
    chk("bubble_hold_lost", 32'(lost_a), 1);
    R_IN = 1'b0;
    tick();
    chk("bubble_r_out3", 32'(r_out_a), 1);
    chk("bubble_d_out_b", 32'(d_out_a), 32'h0003);

    drive(1'b1, 2'b11, 16'hABCD, 4'd8, 32'h1234_5678, 5'd8);
    tick();
    drive(1'b1, 2'b10, 16'h00FF, 4'd3, 32'h00FF_00FF, 5'd3);
    RST = 1'b1;
    tick();
    chk("midrst_r_out", 32'(r_out_a), 0);
    chk("midrst_d_out", 32'(d_out_a), 0);
    chk("midrst_lost", 32'(lost_a), 0);
    RST = 1'b0; R_IN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("midrst_quiet%0d", i), 32'(r_out_a), 0);
    end

    drive(1'b1, 2'b01, 16'h8000, 4'd15, 32'h8000_0000, 5'd31);
    tick();
    R_IN = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("w32_sra31_r_out", 32'(r_out_c), 1);
    chk("w32_sra31_d_out", d_out_c, 32'hFFFF_FFFF);
    chk("w32_sra31_lost", 32'(lost_c), 0);

    for (int i = 0; i < 300; i++) begin
      EN = ($urandom_range(0, 3) != 0);
      drive(1'($urandom), 2'($urandom), 16'($urandom), 4'($urandom), $urandom, 5'($urandom));
      tick();
    end
    EN = 1'b1; R_IN = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("drain_sb%0d_empty", i), 32'(sbq[i].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
